// File: rtl/ethernet_tx_mmio_initiator.sv
// Streams one packet into an MMIO TX buffer after polling status, then writes size and send.
// Optional: `define ETH_TX_MMIO_POLL_TIMEOUT_EN bounds status polling to poll_limit_p attempts.
module ethernet_tx_mmio_initiator #(
  parameter int          buf_size_p       = 2048,
  parameter int          axis_width_p     = 64,
  parameter logic [15:0] tx_buf_base_p    = 16'h0800,
  parameter logic [15:0] tx_send_addr_p   = 16'h1010,
  parameter logic [15:0] tx_status_addr_p = 16'h1014,
  parameter logic [15:0] tx_size_addr_p   = 16'h1018,
  parameter int          poll_limit_p     = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [axis_width_p-1:0] data_i,
  input  logic                    v_i,
  input  logic                    last_i,
  input  logic [2:0]              last_bytes_i,
  output logic                    ready_o,
  output logic [15:0]             addr_o,
  output logic                    write_en_o,
  output logic                    read_en_o,
  output logic [1:0]              op_size_o,
  output logic [axis_width_p-1:0] write_data_o,
  input  logic [axis_width_p-1:0] read_data_i,
  input  logic                    read_data_v_i,
  output logic                    done_o,
  output logic                    error_o
);

  localparam int off_w_lp = $clog2(buf_size_p) + 1;

  typedef enum logic [2:0] {IDLE, POLL, WAIT_RD, STREAM, SIZE, SEND, DRAIN} state_e;

  state_e              r_state, w_next;
  logic [off_w_lp-1:0] r_offset;
  logic [11:0]         r_count;
  logic                w_accept;
  logic                w_overflow;
  logic [3:0]          w_bytes;
  logic                w_unused_rd;

  // Only the ready bit of the status word matters.
  assign w_unused_rd = ^{read_data_i[axis_width_p-1:1], 32'(poll_limit_p)};
  assign w_accept    = v_i & ready_o;
  assign w_overflow  = (int'(r_offset) + 8) > buf_size_p;
  assign w_bytes     = (last_i && last_bytes_i != 3'd0) ? {1'b0, last_bytes_i} : 4'd8;

`ifdef ETH_TX_MMIO_POLL_TIMEOUT_EN
  localparam int poll_w_lp = $clog2(poll_limit_p + 1);
  logic [poll_w_lp-1:0] r_poll_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i || r_state == IDLE || r_state == STREAM) r_poll_cnt <= '0;
    else if (r_state == POLL)                            r_poll_cnt <= r_poll_cnt + 1'b1;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || r_state == IDLE) begin
      r_offset <= '0;
      r_count  <= '0;
    end else if (r_state == STREAM && w_accept && !w_overflow) begin
      r_offset <= r_offset + off_w_lp'(8);
      r_count  <= r_count + 12'(w_bytes);
    end
  end

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (v_i) w_next = POLL;
      POLL:    w_next = WAIT_RD;
      WAIT_RD: begin
        if (read_data_v_i) begin
          if (read_data_i[0]) w_next = STREAM;
`ifdef ETH_TX_MMIO_POLL_TIMEOUT_EN
          else if (int'(r_poll_cnt) >= poll_limit_p) w_next = DRAIN;
`endif
          else w_next = POLL;
        end
      end
      STREAM: begin
        if (w_accept) begin
          if (w_overflow) w_next = last_i ? IDLE : DRAIN;
          else            w_next = last_i ? SIZE : STREAM;
        end
      end
      SIZE:    w_next = SEND;
      SEND:    w_next = IDLE;
      DRAIN:   if (w_accept && last_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced idle while reset is held so an abandoned packet emits nothing.
  always_comb begin
    ready_o      = 1'b0;
    write_en_o   = 1'b0;
    read_en_o    = 1'b0;
    op_size_o    = 2'd0;
    addr_o       = 16'h0;
    write_data_o = '0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    if (!reset_i) begin
      case (r_state)
        POLL: begin
          read_en_o = 1'b1;
          addr_o    = tx_status_addr_p;
          op_size_o = 2'd3;
        end
        STREAM: begin
          ready_o = 1'b1;
          if (v_i && !w_overflow) begin
            write_en_o   = 1'b1;
            op_size_o    = 2'd3;
            addr_o       = tx_buf_base_p + 16'(r_offset);
            write_data_o = data_i;
          end else if (v_i && last_i) begin
            error_o = 1'b1;
          end
        end
        SIZE: begin
          write_en_o   = 1'b1;
          addr_o       = tx_size_addr_p;
          op_size_o    = 2'd1;
          write_data_o = axis_width_p'(r_count);
        end
        SEND: begin
          write_en_o   = 1'b1;
          addr_o       = tx_send_addr_p;
          op_size_o    = 2'd2;
          write_data_o = axis_width_p'(1);
          done_o       = 1'b1;
        end
        DRAIN: begin
          ready_o = 1'b1;
          error_o = v_i & last_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_tx_mmio_initiator.sv
// Bench for ethernet_tx_mmio_initiator: random packet data and status replies, checked
// against an expected MMIO transaction list derived from packet length and poll outcome.
module tb_ethernet_tx_mmio_initiator;

  localparam int BUF_SIZE   = 2048;
  localparam int POLL_LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] data_i;
  logic        v_i;
  logic        last_i;
  logic [2:0]  last_bytes_i;
  logic        ready_o;
  logic [15:0] addr_o;
  logic        write_en_o;
  logic        read_en_o;
  logic [1:0]  op_size_o;
  logic [63:0] write_data_o;
  logic [63:0] read_data_i;
  logic        read_data_v_i;
  logic        done_o;
  logic        error_o;

  ethernet_tx_mmio_initiator #(.poll_limit_p(POLL_LIMIT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .last_i(last_i),
    .last_bytes_i(last_bytes_i), .ready_o(ready_o), .addr_o(addr_o),
    .write_en_o(write_en_o), .read_en_o(read_en_o), .op_size_o(op_size_o),
    .write_data_o(write_data_o), .read_data_i(read_data_i),
    .read_data_v_i(read_data_v_i), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } op_t;

  op_t obs_q[$];
  int  done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int  n_vec = 0, n_err = 0;
  int  pkt_start = 0;

  // Bus monitor: one log entry per cycle that carries an MMIO strobe.
  always @(negedge clk_i) begin
    op_t o;
    #3;
    if (write_en_o && read_en_o) both_cnt++;
    if (write_en_o || read_en_o) begin
      o = '{wr: write_en_o, addr: addr_o, size: op_size_o, data: write_data_o};
      obs_q.push_back(o);
    end
    if (done_o)  done_cnt++;
    if (error_o) err_cnt++;
  end

  // Status responder: answers each read after 1..3 cycles from a scripted reply list.
  bit status_q[$];
  int st_rd = 0, lat = 0;
  bit pend_stat = 1'b0, inject_stale = 1'b0;

  always @(negedge clk_i) begin
    #1;
    read_data_v_i = 1'b0;
    if (inject_stale) begin
      read_data_v_i = 1'b1;
      read_data_i   = 64'h1;
    end else if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        read_data_v_i = 1'b1;
        read_data_i   = {$urandom, 31'($urandom), pend_stat};
      end
    end
    if (read_en_o) begin
      lat       = $urandom_range(1, 3);
      pend_stat = (st_rd < status_q.size()) ? status_q[st_rd] : 1'b1;
      st_rd++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int reads_since_start();
    int r = 0;
    for (int j = pkt_start; j < obs_q.size(); j++) if (!obs_q[j].wr) r++;
    return r;
  endfunction

  // Presents one word and holds it until accepted; gives up after a cycle budget.
  task automatic drive_word(input logic [63:0] d, input bit l, input logic [2:0] b,
                            output bit ok, output int reads_at_accept);
    ok = 1'b0;
    reads_at_accept = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk_i); #2;
      v_i = 1'b1; data_i = d; last_i = l; last_bytes_i = b;
      #1;
      if (ready_o) begin
        ok = 1'b1;
        reads_at_accept = reads_since_start();
        break;
      end
    end
    if (!ok) check("word accept timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_inputs();
    @(negedge clk_i); #2;
    v_i = 1'b0; last_i = 1'b0; data_i = '0; last_bytes_i = '0;
  endtask

  task automatic compare_ops(input string tag, input op_t exp[$]);
    int n_obs = obs_q.size() - pkt_start;
    check({tag, " op count"}, 64'(n_obs), 64'(exp.size()));
    for (int j = 0; j < exp.size() && j < n_obs; j++) begin
      op_t o = obs_q[pkt_start + j];
      check({tag, " op kind"}, 64'(o.wr), 64'(exp[j].wr));
      check({tag, " op addr"}, 64'(o.addr), 64'(exp[j].addr));
      if (exp[j].addr != 16'h1010) check({tag, " op size"}, 64'(o.size), 64'(exp[j].size));
      if (exp[j].wr) check({tag, " op data"}, o.data, exp[j].data);
    end
  endtask

  // Reference: polls until first ready status (or limit), then buffer writes at 8-byte
  // steps while they fit, then size and send; an overflowing or timed-out packet errors.
  task automatic run_packet(input string tag, input int n, input logic [2:0] lb,
                            input int zeros, input bit gaps);
    logic [63:0] d[$];
    op_t exp[$];
    op_t e;
    int  d0, e0, polls, reads_at, bytes;
    bit  timed = 1'b0, ovf = 1'b0, ok;
`ifdef ETH_TX_MMIO_POLL_TIMEOUT_EN
    if (zeros >= POLL_LIMIT) begin timed = 1'b1; zeros = POLL_LIMIT; end
`endif
    pkt_start = obs_q.size();
    d0 = done_cnt; e0 = err_cnt;
    for (int z = 0; z < zeros; z++) status_q.push_back(1'b0);
    if (!timed) status_q.push_back(1'b1);
    polls = timed ? zeros : zeros + 1;
    for (int i = 0; i < n; i++) d.push_back({$urandom, $urandom});

    for (int p = 0; p < polls; p++) begin
      e = '{wr: 1'b0, addr: 16'h1014, size: 2'd3, data: 64'd0};
      exp.push_back(e);
    end
    if (!timed) begin
      for (int i = 0; i < n; i++) begin
        if (8 * i + 8 > BUF_SIZE) begin ovf = 1'b1; break; end
        e = '{wr: 1'b1, addr: 16'h0800 + 16'(8 * i), size: 2'd3, data: d[i]};
        exp.push_back(e);
      end
      if (!ovf) begin
        bytes = 8 * (n - 1) + ((lb == 3'd0) ? 8 : int'(lb));
        e = '{wr: 1'b1, addr: 16'h1018, size: 2'd1, data: 64'(bytes)};
        exp.push_back(e);
        e = '{wr: 1'b1, addr: 16'h1010, size: 2'd2, data: 64'd1};
        exp.push_back(e);
      end
    end

    for (int i = 0; i < n; i++) begin
      drive_word(d[i], i == n - 1, lb, ok, reads_at);
      if (!ok) break;
      if (i == 0) check({tag, " polls before ready"}, 64'(reads_at), 64'(polls));
      if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) idle_inputs();
    end
    idle_inputs();
    repeat (4) @(negedge clk_i);
    #4;
    compare_ops(tag, exp);
    check({tag, " done pulses"}, 64'(done_cnt - d0), 64'(!timed && !ovf));
    check({tag, " error pulses"}, 64'(err_cnt - e0), 64'(timed || ovf));
  endtask

  initial begin
    op_t exp[$];
    op_t e;
    logic [63:0] w0, w1;
    int reads_at;
    bit ok;

    reset_i = 1'b1; v_i = 1'b0; last_i = 1'b0; data_i = '0; last_bytes_i = '0;
    read_data_i = '0; read_data_v_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #3;
    check("reset ready_o", 64'(ready_o), 64'd0);
    check("reset write_en_o", 64'(write_en_o), 64'd0);
    check("reset read_en_o", 64'(read_en_o), 64'd0);
    check("reset done_o", 64'(done_o), 64'd0);
    check("reset error_o", 64'(error_o), 64'd0);
    check("reset addr_o", 64'(addr_o), 64'd0);
    check("reset op_size_o", 64'(op_size_o), 64'd0);
    check("reset write_data_o", write_data_o, 64'd0);
    @(negedge clk_i); #2;
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    run_packet("basic3", 3, 3'd4, 0, 1'b0);
    run_packet("poll3", 5, 3'd7, 2, 1'b1);
    run_packet("exact_fit", 256, 3'd0, 0, 1'b0);
    run_packet("overflow", 257, 3'd0, 0, 1'b0);
    run_packet("after_ovf", 2, 3'd1, 0, 1'b0);

    // Reset after two accepted words, stale read response, then a fresh packet.
    pkt_start = obs_q.size();
    status_q.push_back(1'b1);
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    drive_word(w0, 1'b0, 3'd0, ok, reads_at);
    drive_word(w1, 1'b0, 3'd0, ok, reads_at);
    @(negedge clk_i); #2;
    v_i = 1'b0; reset_i = 1'b1;
    @(negedge clk_i); #3;
    check("mid reset write_en_o", 64'(write_en_o), 64'd0);
    check("mid reset read_en_o", 64'(read_en_o), 64'd0);
    check("mid reset ready_o", 64'(ready_o), 64'd0);
    check("mid reset done/error", 64'({done_o, error_o}), 64'd0);
    @(negedge clk_i); #2;
    reset_i = 1'b0; inject_stale = 1'b1;
    @(negedge clk_i); #2;
    inject_stale = 1'b0;
    repeat (3) @(negedge clk_i);
    #4;
    e = '{wr: 1'b0, addr: 16'h1014, size: 2'd3, data: 64'd0}; exp.push_back(e);
    e = '{wr: 1'b1, addr: 16'h0800, size: 2'd3, data: w0};    exp.push_back(e);
    e = '{wr: 1'b1, addr: 16'h0808, size: 2'd3, data: w1};    exp.push_back(e);
    compare_ops("abandoned", exp);
    run_packet("post_reset", 4, 3'd3, 0, 1'b0);

`ifdef ETH_TX_MMIO_POLL_TIMEOUT_EN
    run_packet("poll_timeout", 5, 3'd2, POLL_LIMIT, 1'b1);
    run_packet("after_timeout", 3, 3'd5, 1, 1'b0);
`endif

    for (int k = 0; k < 6; k++)
      run_packet("random", $urandom_range(1, 24), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2), 1'b1);

    check("rd/wr same cycle", 64'(both_cnt), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ethernet_tx_mmio_initiator.md
ETHERNET_TX_MMIO_INITIATOR -- requirements
Module: ethernet_tx_mmio_initiator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- buf_size_p, 2048, TX buffer bytes.
- axis_width_p, 64, data/MMIO word width.
- tx_buf_base_p, 16'h0800, MMIO address of TX buffer byte 0.
- tx_send_addr_p, 16'h1010, send register.
- tx_status_addr_p, 16'h1014, bit0 = TX ready.
- tx_size_addr_p, 16'h1018, TX packet size register.
- poll_limit_p, 1024, max status polls per packet.
REQ-002 Ports SHALL be (name direction width meaning); one clock; reset is synchronous and active-high:
- clk_i  in  1  sole clock
- reset_i  in  1  synchronous active-high reset
- data_i  in  64  packet word, byte 0 in bits [7:0]
- v_i  in  1  data_i valid
- last_i  in  1  final word of packet
- last_bytes_i  in  3  valid bytes in final word, 0 = 8
- ready_o  out  1  word accepted when v_i & ready_o
- addr_o  out  16  MMIO address
- write_en_o  out  1  MMIO write strobe
- read_en_o  out  1  MMIO read strobe
- op_size_o  out  2  log2 bytes (3 = 8 bytes)
- write_data_o  out  64  MMIO write data
- read_data_i  in  64  MMIO read data
- read_data_v_i  in  1  read_data_i valid
- done_o  out  1  one-cycle pulse, packet sent
- error_o  out  1  one-cycle pulse, packet dropped

Function
REQ-003 FSM states SHALL be IDLE, POLL, WAIT_RD, STREAM, SIZE, SEND, DRAIN.
REQ-004 IDLE: ready_o=0; v_i=1 -> POLL next cycle; data not consumed.
REQ-005 POLL: exactly one cycle read_en_o=1, addr_o=tx_status_addr_p, op_size_o=3 -> WAIT_RD; poll counter increments.
REQ-006 WAIT_RD: all strobes 0 until read_data_v_i; read_data_i[0]=1 -> STREAM, else POLL; counter cleared on entering STREAM.
REQ-007 STREAM: ready_o=1; each accepted word SHALL, same cycle, drive write_en_o=1, op_size_o=3, addr_o=tx_buf_base_p+offset, write_data_o=data_i; offset then +=8.
REQ-008 Byte count (12 bits) SHALL accumulate 8 per non-last word and last_bytes_i (0 -> 8) on the last word.
REQ-009 Accepted last_i word -> SIZE: one cycle write_en_o=1, addr_o=tx_size_addr_p, op_size_o=1, write_data_o=byte count zero-extended.
REQ-010 SIZE -> SEND: one cycle write_en_o=1, addr_o=tx_send_addr_p, write_data_o=1; done_o=1 same cycle; -> IDLE.
REQ-011 Overflow: a non-last word accepted when offset+8 > buf_size_p SHALL NOT be written; -> DRAIN.
REQ-012 DRAIN: ready_o=1, no MMIO strobes; words discarded; accepted last_i -> error_o=1 that cycle, -> IDLE; no SIZE/SEND issued.
REQ-013 A last word at offset buf_size_p-8 SHALL be written and sent normally (exact-fit, count 2048).
REQ-014 write_en_o and read_en_o SHALL never be asserted in the same cycle; at most one MMIO op per cycle.
REQ-015 Offset, byte count, poll counter SHALL clear on every return to IDLE.

Reset
REQ-016 reset_i SHALL force IDLE, clear counters, and drive ready_o, write_en_o, read_en_o, done_o, error_o to 0; addr_o, op_size_o, write_data_o to 0.
REQ-017 Reset mid-packet SHALL abandon it with no further MMIO writes; stale read_data_v_i after reset SHALL be ignored.

Configuration
REQ-018 Macro ETH_TX_MMIO_POLL_TIMEOUT_EN: defined -> WAIT_RD with read_data_i[0]=0 after poll_limit_p polls -> DRAIN (packet consumed, error_o at its last word); undefined -> polling unbounded, no poll counter logic.

Verification
REQ-019 Status=1 on first poll, 3 words, last_bytes_i=4 -> writes 0x0800/0x0808/0x0810, size write 20, send write 1, done_o once.
REQ-020 Status=0 twice then 1 -> exactly 3 reads to 0x1014 before first buffer write; ready_o=0 until then.
REQ-021 256 words, last_bytes_i=0 -> last write 0x0FF8, size 2048, done_o.
REQ-022 257 words -> 256 buffer writes, no size/send writes, error_o at word 257, next packet sent normally.
REQ-023 Macro defined, poll_limit_p=4, status always 0 -> 4 reads, packet drained, error_o=1, no writes.
REQ-024 reset_i asserted after 2 words -> all strobes 0 next cycle, IDLE; fresh packet then sent with count from 0.
